// File: rtl/fdiv_iter.sv
// Iterative IEEE-754 single-precision divider, y = x1 / x2.
// Radix-2 restoring division of the mantissas (BITS_PER_CYC quotient bits per cycle),
// followed by a single normalise/round-to-nearest-even cycle. Fixed latency of
// 26/BITS_PER_CYC + 1 cycles from the accept edge to out_valid, special cases included.
// Denormal inputs are flushed to zero and no denormal result is ever produced.
//
// Ports:
//   clk        clock, rising edge
//   rstn       asynchronous active-low reset; discards any operation in flight
//   x1, x2     dividend / divisor, IEEE single
//   in_valid   operands valid
//   in_ready   divider idle; operands accepted when in_valid & in_ready
//   y          quotient, IEEE single, held while out_valid
//   out_valid  result valid, held until out_ready
//   out_ready  consumer takes y
module fdiv_iter #(
    parameter int unsigned BITS_PER_CYC = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] y,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int unsigned NumCyc  = 26 / BITS_PER_CYC;
    localparam logic [4:0]  CntLast = 5'(NumCyc - 1);

    typedef enum logic [1:0] {StIdle, StDiv, StRound, StDone} state_e;
    typedef enum logic [1:0] {ClsNorm, ClsNan, ClsInf, ClsZero} cls_e;

    state_e             state_q, state_d;
    cls_e               cls_q, cls_d;
    logic               sign_q, sign_d;
    logic signed [9:0]  e_q, e_d;
    logic [23:0]        mx2_q, mx2_d;
    logic [25:0]        rem_q, rem_d;
    logic [25:0]        q_q, q_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [31:0]        y_q, y_d;

    // Operand classification
    logic x1_zero, x1_inf, x1_nan, x2_zero, x2_inf, x2_nan;
    cls_e cls_in;

    always_comb begin
        x1_zero = (x1[30:23] == 8'h00);
        x2_zero = (x2[30:23] == 8'h00);
        x1_inf  = (x1[30:23] == 8'hFF) && (x1[22:0] == 23'd0);
        x2_inf  = (x2[30:23] == 8'hFF) && (x2[22:0] == 23'd0);
        x1_nan  = (x1[30:23] == 8'hFF) && (x1[22:0] != 23'd0);
        x2_nan  = (x2[30:23] == 8'hFF) && (x2[22:0] != 23'd0);
        if (x1_nan || x2_nan || (x1_zero && x2_zero) || (x1_inf && x2_inf)) begin
            cls_in = ClsNan;
        end else if (x1_inf || x2_zero) begin
            cls_in = ClsInf;
        end else if (x1_zero || x2_inf) begin
            cls_in = ClsZero;
        end else begin
            cls_in = ClsNorm;
        end
    end

    // Restoring division steps for one cycle. rem holds the partial remainder
    // pre-shifted for the next compare, so it stays below 2*mx2 < 2^25.
    logic [25:0] rem_n, q_n;

    always_comb begin
        rem_n = rem_q;
        q_n   = q_q;
        for (int i = 0; i < int'(BITS_PER_CYC); i++) begin
            if (rem_n >= {2'b00, mx2_q}) begin
                rem_n = rem_n - {2'b00, mx2_q};
                q_n   = {q_n[24:0], 1'b1};
            end else begin
                q_n   = {q_n[24:0], 1'b0};
            end
            rem_n = rem_n << 1;
        end
    end

    // Normalise and round to nearest even
    logic [23:0]       sig;
    logic              guard, sticky, round_up;
    logic [24:0]       sig_r;
    logic [22:0]       frac;
    logic signed [9:0] e_adj, e_f;
    logic [31:0]       y_round;
    logic              unused_sig_msb;

    always_comb begin
        if (q_q[25]) begin
            sig    = q_q[25:2];
            guard  = q_q[1];
            sticky = q_q[0] | (rem_q != 26'd0);
        end else begin
            sig    = q_q[24:1];
            guard  = q_q[0];
            sticky = (rem_q != 26'd0);
        end
        round_up = guard & (sticky | sig[0]);
        sig_r    = {1'b0, sig} + {24'd0, round_up};
        e_adj    = e_q - $signed({9'd0, ~q_q[25]});
        // Carry out of the significand: value becomes exactly 1.0 at the next exponent
        if (sig_r[24]) begin
            frac = 23'd0;
            e_f  = e_adj + 10'sd1;
        end else begin
            frac = sig_r[22:0];
            e_f  = e_adj;
        end
        unique case (cls_q)
            ClsNan:  y_round = 32'h7FC0_0000;
            ClsInf:  y_round = {sign_q, 8'hFF, 23'd0};
            ClsZero: y_round = {sign_q, 31'd0};
            default: begin
                if (e_f >= 10'sd255) begin
                    y_round = {sign_q, 8'hFF, 23'd0};
                end else if (e_f <= 10'sd0) begin
                    y_round = {sign_q, 31'd0};
                end else begin
                    y_round = {sign_q, e_f[7:0], frac};
                end
            end
        endcase
    end

    // Hidden bit of the rounded significand is implied by the exponent
    assign unused_sig_msb = sig_r[23];

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        sign_d  = sign_q;
        e_d     = e_q;
        mx2_d   = mx2_q;
        rem_d   = rem_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    cls_d   = cls_in;
                    sign_d  = x1[31] ^ x2[31];
                    e_d     = $signed({2'b00, x1[30:23]}) - $signed({2'b00, x2[30:23]})
                              + 10'sd127;
                    rem_d   = {2'b01, x1[22:0], 1'b0} >> 1;
                    mx2_d   = {1'b1, x2[22:0]};
                    q_d     = 26'd0;
                    cnt_d   = 5'd0;
                    state_d = StDiv;
                end
            end
            StDiv: begin
                rem_d = rem_n;
                q_d   = q_n;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == CntLast) begin
                    state_d = StRound;
                end
            end
            StRound: begin
                y_d     = y_round;
                state_d = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            cls_q   <= ClsNorm;
            sign_q  <= 1'b0;
            e_q     <= 10'sd0;
            mx2_q   <= 24'd0;
            rem_q   <= 26'd0;
            q_q     <= 26'd0;
            cnt_q   <= 5'd0;
            y_q     <= 32'd0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            sign_q  <= sign_d;
            e_q     <= e_d;
            mx2_q   <= mx2_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign y         = y_q;

endmodule

// File: tb/tb_fdiv_iter.sv
module tb_fdiv_iter;

    logic        clk;
    logic        rstn;
    logic [31:0] x1, x2;
    logic        in_valid1, in_ready1, out_valid1, out_ready1;
    logic        in_valid2, in_ready2, out_valid2, out_ready2;
    logic [31:0] y1, y2;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    fdiv_iter #(.BITS_PER_CYC(1)) dut1 (
        .clk       (clk),
        .rstn      (rstn),
        .x1        (x1),
        .x2        (x2),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .y         (y1),
        .out_valid (out_valid1),
        .out_ready (out_ready1)
    );

    fdiv_iter #(.BITS_PER_CYC(2)) dut2 (
        .clk       (clk),
        .rstn      (rstn),
        .x1        (x1),
        .x2        (x2),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .y         (y2),
        .out_valid (out_valid2),
        .out_ready (out_ready2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present operands for one accept edge, then scramble them; expected result queued.
    task automatic accept(input bit sel, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] want);
        x1 = a;
        x2 = b;
        if (sel) in_valid2 = 1'b1; else in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        in_valid2 = 1'b0;
        exp_q.push_back(want);
        x1 = $urandom;
        x2 = $urandom;
    endtask

    // Cycles from the accept edge until out_valid, bounded at 200.
    task automatic wait_out(input bit sel, output int cyc, output bit rdy_seen);
        cyc = 0;
        rdy_seen = 1'b0;
        while (!(sel ? out_valid2 : out_valid1) && cyc < 200) begin
            if (sel ? in_ready2 : in_ready1) rdy_seen = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic release_out(input bit sel);
        if (sel) out_ready2 = 1'b1; else out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;
        out_ready2 = 1'b0;
    endtask

    function automatic logic [31:0] pop_exp();
        if (exp_q.size() == 0) return 32'hDEAD_BEEF;
        return exp_q.pop_front();
    endfunction

    task automatic test_reset();
        rstn = 1'b0;
        #3;
        total++; if (y1 !== 32'h0) begin bad++; $display("FAIL reset_y1 got=%h want=0", y1); end
        total++; if (out_valid1 !== 1'b0) begin bad++; $display("FAIL reset_ov1 got=%b want=0", out_valid1); end
        total++; if (in_ready1 !== 1'b1) begin bad++; $display("FAIL reset_ir1 got=%b want=1", in_ready1); end
        total++; if (in_ready2 !== 1'b1) begin bad++; $display("FAIL reset_ir2 got=%b want=1", in_ready2); end
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [31:0] a[3]    = '{32'h40C0_0000, 32'h3F80_0000, 32'hBF80_0000};
        logic [31:0] b[3]    = '{32'h4000_0000, 32'h4040_0000, 32'h4000_0000};
        logic [31:0] want[3] = '{32'h4040_0000, 32'h3EAA_AAAB, 32'hBF00_0000};
        int cyc; bit rdy; logic [31:0] w;
        for (int i = 0; i < 3; i++) begin
            accept(1'b0, a[i], b[i], want[i]);
            wait_out(1'b0, cyc, rdy);
            total++; if (cyc !== 27) begin bad++; $display("FAIL basic_latency[%0d] got=%0d want=27", i, cyc); end
            total++; if (rdy !== 1'b0) begin bad++; $display("FAIL basic_in_ready_busy[%0d] got=%b want=0", i, rdy); end
            w = pop_exp();
            total++; if (y1 !== w) begin bad++; $display("FAIL basic_y[%0d] got=%h want=%h", i, y1, w); end
            release_out(1'b0);
            total++; if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin
                bad++; $display("FAIL basic_after_hs[%0d] got ir=%b ov=%b want ir=1 ov=0", i, in_ready1, out_valid1);
            end
        end
    endtask

    task automatic test_special();
        logic [31:0] a[6]    = '{32'h3F80_0000, 32'h0000_0000, 32'h0000_0000,
                                 32'h007F_FFFF, 32'h7F00_0000, 32'h0080_0000};
        logic [31:0] b[6]    = '{32'h0000_0000, 32'h0000_0000, 32'h40A0_0000,
                                 32'h3F80_0000, 32'h0080_0000, 32'h7F00_0000};
        logic [31:0] want[6] = '{32'h7F80_0000, 32'h7FC0_0000, 32'h0000_0000,
                                 32'h0000_0000, 32'h7F80_0000, 32'h0000_0000};
        int cyc; bit rdy; logic [31:0] w;
        for (int i = 0; i < 6; i++) begin
            accept(1'b0, a[i], b[i], want[i]);
            wait_out(1'b0, cyc, rdy);
            total++; if (cyc !== 27) begin bad++; $display("FAIL special_latency[%0d] got=%0d want=27", i, cyc); end
            w = pop_exp();
            total++; if (y1 !== w) begin bad++; $display("FAIL special_y[%0d] got=%h want=%h", i, y1, w); end
            release_out(1'b0);
        end
    endtask

    task automatic test_hold_back_to_back();
        int cyc; bit rdy; bit moved; logic [31:0] y_first, w;
        accept(1'b0, 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000);
        wait_out(1'b0, cyc, rdy);
        total++; if (cyc !== 27) begin bad++; $display("FAIL hold_latency got=%0d want=27", cyc); end
        y_first = y1;
        moved = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (y1 !== y_first || out_valid1 !== 1'b1 || in_ready1 !== 1'b0) moved = 1'b1;
        end
        total++; if (moved !== 1'b0) begin bad++; $display("FAIL hold_stable got=changed want=stable"); end
        w = pop_exp();
        total++; if (y1 !== w) begin bad++; $display("FAIL hold_y got=%h want=%h", y1, w); end
        // Next op presented together with the out handshake; must wait for the idle cycle
        x1 = 32'h3F80_0000;
        x2 = 32'h4040_0000;
        in_valid1  = 1'b1;
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;
        total++; if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
            bad++; $display("FAIL b2b_bubble got ov=%b ir=%b want ov=0 ir=1", out_valid1, in_ready1);
        end
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        exp_q.push_back(32'h3EAA_AAAB);
        x1 = $urandom;
        x2 = $urandom;
        total++; if (in_ready1 !== 1'b0) begin bad++; $display("FAIL b2b_accept got ir=%b want=0", in_ready1); end
        wait_out(1'b0, cyc, rdy);
        total++; if (cyc !== 27) begin bad++; $display("FAIL b2b_latency got=%0d want=27", cyc); end
        w = pop_exp();
        total++; if (y1 !== w) begin bad++; $display("FAIL b2b_y got=%h want=%h", y1, w); end
        release_out(1'b0);
    endtask

    task automatic test_reset_mid(input bit sel);
        int cyc; bit rdy; bit rose; logic [31:0] w;
        int lat = sel ? 14 : 27;
        accept(sel, 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000);
        repeat (9) begin @(posedge clk); #1; end
        rstn = 1'b0;
        #2;
        total++; if ((sel ? in_ready2 : in_ready1) !== 1'b1) begin
            bad++; $display("FAIL rst_mid_ir[%0d] got=%b want=1", sel, sel ? in_ready2 : in_ready1);
        end
        total++; if ((sel ? y2 : y1) !== 32'h0) begin
            bad++; $display("FAIL rst_mid_y[%0d] got=%h want=0", sel, sel ? y2 : y1);
        end
        rstn = 1'b1;
        void'(pop_exp());
        rose = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if ((sel ? out_valid2 : out_valid1) !== 1'b0) rose = 1'b1;
        end
        total++; if (rose !== 1'b0) begin bad++; $display("FAIL rst_mid_no_out[%0d] got=rose want=quiet", sel); end
        accept(sel, 32'hBF80_0000, 32'h4000_0000, 32'hBF00_0000);
        wait_out(sel, cyc, rdy);
        total++; if (cyc !== lat) begin bad++; $display("FAIL rst_mid_latency[%0d] got=%0d want=%0d", sel, cyc, lat); end
        w = pop_exp();
        total++; if ((sel ? y2 : y1) !== w) begin
            bad++; $display("FAIL rst_mid_y_next[%0d] got=%h want=%h", sel, sel ? y2 : y1, w);
        end
        release_out(sel);
    endtask

    task automatic test_bpc2();
        int cyc; bit rdy; logic [31:0] w;
        accept(1'b1, 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB);
        wait_out(1'b1, cyc, rdy);
        total++; if (cyc !== 14) begin bad++; $display("FAIL bpc2_latency got=%0d want=14", cyc); end
        w = pop_exp();
        total++; if (y2 !== w) begin bad++; $display("FAIL bpc2_y got=%h want=%h", y2, w); end
        release_out(1'b1);
    endtask

    initial begin
        x1 = '0;
        x2 = '0;
        in_valid1 = 1'b0;
        in_valid2 = 1'b0;
        out_ready1 = 1'b0;
        out_ready2 = 1'b0;
        rstn = 1'b1;
        test_reset();
        test_basic();
        test_special();
        test_hold_back_to_back();
        test_reset_mid(1'b0);
        test_bpc2();
        test_reset_mid(1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
